qpu_ifu2exu_queue: RTL and testbench

Instruction queue between the IFU IR stage and the EXU decode/dispatch stage.
- Accepts fetched entries {ir, pc, pc_vld, rs1idx, rs2idx, prdt_taken} from the IFU over a valid/ready handshake.
- Buffers up to DEPTH entries and presents them in order to the EXU over a second valid/ready handshake.
- Decouples IFU fetch from EXU stalls and discards all buffered entries on a pipeline flush.

---
 rtl/qpu_ifu2exu_queue.sv | 116 +++++++++++
 tb/tb_qpu_ifu2exu_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_ifu2exu_queue.sv
// IFU-to-EXU instruction queue: DEPTH-entry FIFO with wrap-bit pointers and flush.
// Optional same-cycle bypass on an empty queue, enabled by defining QPU_IQ_BYPASS_EN.
module qpu_ifu2exu_queue #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int RFIDX_W = 5,
  parameter int CNT_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [INSTR_W-1:0] i_ir,
  input  logic [PC_W-1:0]    i_pc,
  input  logic               i_pc_vld,
  input  logic [RFIDX_W-1:0] i_rs1idx,
  input  logic [RFIDX_W-1:0] i_rs2idx,
  input  logic               i_prdt_taken,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [INSTR_W-1:0] o_ir,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_pc_vld,
  output logic [RFIDX_W-1:0] o_rs1idx,
  output logic [RFIDX_W-1:0] o_rs2idx,
  output logic               o_prdt_taken,
  input  logic               flush_req,
  output logic               flush_ack,
  output logic [CNT_W-1:0]   q_count,
  output logic               q_empty
);

  localparam int IDX_W = CNT_W - 1;
  localparam int ENT_W = INSTR_W + PC_W + 1 + 2 * RFIDX_W + 1;

  logic [ENT_W-1:0] mem_r [DEPTH];
  logic [CNT_W-1:0] wptr_r;
  logic [CNT_W-1:0] rptr_r;

  logic [ENT_W-1:0] in_ent_s;
  logic [ENT_W-1:0] out_ent_s;
  logic             empty_s;
  logic             full_s;
  logic             byp_s;
  logic             push_s;
  logic             pop_s;
  logic             i_ready_s;
  logic             o_valid_s;

  assign in_ent_s = {i_ir, i_pc, i_pc_vld, i_rs1idx, i_rs2idx, i_prdt_taken};

  // Occupancy flags derived from wrap-bit pointers
  assign empty_s = (wptr_r == rptr_r);
  assign full_s  = (wptr_r[IDX_W-1:0] == rptr_r[IDX_W-1:0]) &&
                   (wptr_r[CNT_W-1] != rptr_r[CNT_W-1]);

  // Handshake qualification, bypass selection and head-entry mux
  always_comb begin
    byp_s = 1'b0;
`ifdef QPU_IQ_BYPASS_EN
    // An empty queue hands the incoming entry straight to a ready EXU
    byp_s = empty_s & ~flush_req & i_valid & o_ready;
`endif
    i_ready_s = ~full_s & ~flush_req;
    push_s    = i_valid & i_ready_s & ~byp_s;
    pop_s     = ~empty_s & ~flush_req & o_ready;
    if (byp_s) begin
      o_valid_s = 1'b1;
      out_ent_s = in_ent_s;
    end else begin
      o_valid_s = ~empty_s & ~flush_req;
      out_ent_s = mem_r[rptr_r[IDX_W-1:0]];
    end
  end

  // Write pointer: advances on push; the carry into the MSB toggles the wrap bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= {CNT_W{1'b0}};
    end else if (push_s) begin
      wptr_r <= wptr_r + CNT_W'(1);
    end else begin
      wptr_r <= wptr_r;
    end
  end

  // Read pointer: a flush discards everything by catching up to the write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_r <= {CNT_W{1'b0}};
    end else if (flush_req) begin
      rptr_r <= wptr_r;
    end else if (pop_s) begin
      rptr_r <= rptr_r + CNT_W'(1);
    end else begin
      rptr_r <= rptr_r;
    end
  end

  // Entry storage, intentionally left unreset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r[IDX_W-1:0]] <= in_ent_s;
    end
  end

  assign {o_ir, o_pc, o_pc_vld, o_rs1idx, o_rs2idx, o_prdt_taken} = out_ent_s;

  assign i_ready   = i_ready_s;
  assign o_valid   = o_valid_s;
  assign flush_ack = flush_req;
  assign q_count   = wptr_r - rptr_r;
  assign q_empty   = empty_s;

endmodule

// File: tb/tb_qpu_ifu2exu_queue.sv
// Directed self-checking bench for qpu_ifu2exu_queue; expectations follow
// QPU_IQ_BYPASS_EN when that macro is defined for the build.
module tb_qpu_ifu2exu_queue;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_ir;
  logic [31:0] i_pc;
  logic        i_pc_vld;
  logic [4:0]  i_rs1idx;
  logic [4:0]  i_rs2idx;
  logic        i_prdt_taken;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_ir;
  logic [31:0] o_pc;
  logic        o_pc_vld;
  logic [4:0]  o_rs1idx;
  logic [4:0]  o_rs2idx;
  logic        o_prdt_taken;
  logic        flush_req;
  logic        flush_ack;
  logic [2:0]  q_count;
  logic        q_empty;

  int n_checks;
  int n_pass;

  qpu_ifu2exu_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .i_ready      (i_ready),
    .i_ir         (i_ir),
    .i_pc         (i_pc),
    .i_pc_vld     (i_pc_vld),
    .i_rs1idx     (i_rs1idx),
    .i_rs2idx     (i_rs2idx),
    .i_prdt_taken (i_prdt_taken),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_ir         (o_ir),
    .o_pc         (o_pc),
    .o_pc_vld     (o_pc_vld),
    .o_rs1idx     (o_rs1idx),
    .o_rs2idx     (o_rs2idx),
    .o_prdt_taken (o_prdt_taken),
    .flush_req    (flush_req),
    .flush_ack    (flush_ack),
    .q_count      (q_count),
    .q_empty      (q_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; stimulus changes there
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    i_valid      = 1'b0;
    i_ir         = 32'h0;
    i_pc         = 32'h0;
    i_pc_vld     = 1'b1;
    i_rs1idx     = 5'd0;
    i_rs2idx     = 5'd0;
    i_prdt_taken = 1'b0;
    o_ready      = 1'b0;
    flush_req    = 1'b0;

    // Reset state
    tick();
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_i_ready", 64'(i_ready), 64'd1);
    chk("rst_q_count", 64'(q_count), 64'd0);
    chk("rst_q_empty", 64'(q_empty), 64'd1);
    rst_n = 1'b1;
    tick();

    // Fill to DEPTH with EXU stalled, then a rejected fifth push
    i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_pc = 32'(4 * k);
      tick();
    end
    i_pc = 32'h10;
    #1;
    chk("full_count", 64'(q_count), 64'd4);
    chk("full_i_ready", 64'(i_ready), 64'd0);
    tick();
    chk("full_no_push", 64'(q_count), 64'd4);
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_valid", 64'(o_valid), 64'd1);
      chk("drain_pc", 64'(o_pc), 64'(4 * k));
      tick();
    end
    #1;
    chk("drain_done_valid", 64'(o_valid), 64'd0);
    chk("drain_done_empty", 64'(q_empty), 64'd1);

    // Streaming 20 entries with both sides ready; wraps the pointers
    tick();
    i_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      i_pc = 32'h200 + 32'(4 * k);
      #1;
`ifdef QPU_IQ_BYPASS_EN
      chk("stream_byp_pc", 64'(o_pc), 64'(32'h200 + 32'(4 * k)));
      chk("stream_byp_count", 64'(q_count), 64'd0);
`else
      if (k > 0) begin
        chk("stream_pc", 64'(o_pc), 64'(32'h200 + 32'(4 * (k - 1))));
        chk("stream_count", 64'(q_count), 64'd1);
      end else begin
        chk("stream_first_valid", 64'(o_valid), 64'd0);
      end
`endif
      tick();
    end
    i_valid = 1'b0;
    #1;
`ifndef QPU_IQ_BYPASS_EN
    chk("stream_last_pc", 64'(o_pc), 64'(32'h200 + 32'(4 * 19)));
    tick();
`endif
    chk("stream_end_empty", 64'(q_empty), 64'd1);

    // Three entries then a one-cycle flush that also carries a push attempt
    o_ready = 1'b0;
    i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_pc = 32'h40 + 32'(4 * k);
      tick();
    end
    i_pc      = 32'h999;
    flush_req = 1'b1;
    #1;
    chk("flush_pre_count", 64'(q_count), 64'd3);
    chk("flush_ack", 64'(flush_ack), 64'd1);
    chk("flush_o_valid", 64'(o_valid), 64'd0);
    chk("flush_i_ready", 64'(i_ready), 64'd0);
    tick();
    flush_req = 1'b0;
    i_valid   = 1'b0;
    #1;
    chk("flush_count", 64'(q_count), 64'd0);
    chk("flush_empty", 64'(q_empty), 64'd1);
    chk("flush_ack_low", 64'(flush_ack), 64'd0);
    i_valid = 1'b1;
    i_pc    = 32'h100;
    tick();
    i_pc = 32'h104;
    tick();
    i_valid = 1'b0;
    o_ready = 1'b1;
    #1;
    chk("post_flush_pc0", 64'(o_pc), 64'h100);
    tick();
    chk("post_flush_pc1", 64'(o_pc), 64'h104);
    tick();
    chk("post_flush_empty", 64'(q_empty), 64'd1);

    // Asynchronous reset with two entries queued
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_pc    = 32'h300;
    tick();
    i_pc = 32'h304;
    tick();
    i_valid = 1'b0;
    #1;
    chk("mid_pre_count", 64'(q_count), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_count", 64'(q_count), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single entry into an empty queue with EXU ready: latency and field routing
    o_ready      = 1'b1;
    i_valid      = 1'b1;
    i_ir         = 32'h12345678;
    i_pc         = 32'h500;
    i_pc_vld     = 1'b0;
    i_rs1idx     = 5'd17;
    i_rs2idx     = 5'd9;
    i_prdt_taken = 1'b1;
    #1;
`ifdef QPU_IQ_BYPASS_EN
    chk("byp_valid", 64'(o_valid), 64'd1);
    chk("byp_ir", 64'(o_ir), 64'h12345678);
    chk("byp_count", 64'(q_count), 64'd0);
    tick();
    i_valid = 1'b0;
    #1;
    chk("byp_after_empty", 64'(q_empty), 64'd1);
`else
    chk("lat_valid_same", 64'(o_valid), 64'd0);
    tick();
    i_valid  = 1'b0;
    i_ir     = 32'h0;
    i_pc_vld = 1'b1;
    i_rs1idx = 5'd0;
    #1;
    chk("lat_valid_next", 64'(o_valid), 64'd1);
    chk("lat_ir", 64'(o_ir), 64'h12345678);
    chk("lat_pc_vld", 64'(o_pc_vld), 64'd0);
    chk("lat_rs1", 64'(o_rs1idx), 64'd17);
    chk("lat_rs2", 64'(o_rs2idx), 64'd9);
    chk("lat_taken", 64'(o_prdt_taken), 64'd1);
    tick();
    chk("lat_after_empty", 64'(q_empty), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
